multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles a memory state waits for i_mem_ready before it raises o_fault.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  reset, synchronous and active-high.
REQ-004 i_instr  input  32  current instruction register contents; opcode is i_instr[6:0].
REQ-005 i_mem_ready  input  1  memory handshake: the requested access completes this cycle.
REQ-006 i_branch_taken  input  1  ALU branch-compare result, valid in BRANCH state.
REQ-007 o_pc_write  output  1  PC register load strobe.
REQ-008 o_ir_write  output  1  instruction register load strobe.
REQ-009 o_mem_read / o_mem_write  output  1 each  memory request, held until i_mem_ready.
REQ-010 o_addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result register.
REQ-011 o_reg_write  output  1  register file write strobe.
REQ-012 o_alu_a_sel  output  1 (0 = PC, 1 = rs1); o_alu_b_sel  output  2 (0 = rs2, 1 = sign-extended immediate, 2 = constant 4).
REQ-013 o_alu_op  output  2  0 = add, 1 = branch compare, 2 = funct-decoded operation.
REQ-014 o_wb_sel  output  2  writeback source: 0 = ALU result, 1 = memory data, 2 = PC+4, 3 = immediate.
REQ-015 o_state  output  4  current state encoding; o_fault  output  1  sticky fault flag.

Function
REQ-016 States and encodings SHALL be FETCH=0, DECODE=1, EXEC=2, MEM_ADDR=3, MEM_RD=4, MEM_WR=5, WB=6, BRANCH=7, JUMP=8, HALT=9.
REQ-017 FETCH SHALL assert o_mem_read with o_addr_sel=0 and wait for i_mem_ready; on the i_mem_ready cycle it SHALL pulse o_ir_write and o_pc_write (ALU = PC+4), then go to DECODE.
REQ-018 DECODE SHALL last 1 cycle with all strobes low and SHALL branch on opcode: TYPE_R (0110011) or ADDI (0010011) -> EXEC; LD (0000011) or TYPE_S (0100011) -> MEM_ADDR; TYPE_SB (1100011) -> BRANCH; JALR (1100111) or TYPE_UJ (1101111) -> JUMP; TYPE_U (0110111) -> WB with o_wb_sel=3.
REQ-019 Any other opcode in DECODE SHALL set o_fault and go to HALT.
REQ-020 EXEC: 1 cycle, o_alu_op=2, o_alu_b_sel = 1 for ADDI and 0 for TYPE_R, then WB with o_wb_sel=0.
REQ-021 MEM_ADDR: 1 cycle, o_alu_a_sel=1, o_alu_b_sel=1, o_alu_op=0; then go to MEM_RD for LD or MEM_WR for TYPE_S.
REQ-022 MEM_RD and MEM_WR SHALL hold o_addr_sel=1 and their request strobe until i_mem_ready. MEM_RD then goes to WB with o_wb_sel=1; MEM_WR then goes to FETCH.
REQ-023 BRANCH: 1 cycle, o_alu_op=1; o_pc_write=i_branch_taken (target = PC + immediate); then FETCH.
REQ-024 JUMP: 1 cycle, pulse o_pc_write (JALR: rs1+imm, o_alu_a_sel=1; TYPE_UJ: PC+imm, o_alu_a_sel=0); then WB with o_wb_sel=2.
REQ-025 WB: 1 cycle, pulse o_reg_write; then FETCH.
REQ-026 Latencies with zero-wait memory: ALU 4 cycles, load 5, store 4, branch 3, jump 4, TYPE_U 3.
REQ-027 Wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment each cycle i_mem_ready is low.
REQ-028 When the wait counter reaches TIMEOUT with i_mem_ready still low, the block SHALL drop its request, set o_fault and go to HALT.
REQ-029 HALT SHALL be absorbing, with all strobes low, until reset.
REQ-030 All strobes not named for a state SHALL be 0 in that state.
REQ-031 i_instr SHALL be sampled only in DECODE, EXEC, MEM_ADDR, JUMP and WB; i_branch_taken SHALL be sampled only in BRANCH.

Reset
REQ-032 While i_reset is high at a rising edge: state=FETCH, wait counter=0, o_fault=0.
REQ-033 On the cycle after reset, all strobes SHALL be 0 except o_mem_read=1; o_state=0.
REQ-034 Reset asserted mid-access SHALL abandon the access with no o_pc_write, o_reg_write or o_mem_write pulse on the following cycle.

Verification
REQ-035 ADDI (0x00500093) with i_mem_ready always high -> states 0,1,2,6,0; one o_reg_write pulse, o_wb_sel=0.
REQ-036 LD with i_mem_ready low for 3 cycles in MEM_RD -> o_mem_read held for 4 cycles, then WB with o_wb_sel=1.
REQ-037 TYPE_SB with i_branch_taken=0, then again with =1 -> o_pc_write stays 0 in BRANCH, then pulses 1 in BRANCH; total 3 cycles each.
REQ-038 Opcode 0x7F -> o_fault=1 and o_state=9 from the cycle after DECODE; the block stays in HALT for 20 cycles.
REQ-039 TIMEOUT=4 with i_mem_ready held low in FETCH -> o_fault set after the 4th wait cycle, HALT entered; reset then returns o_state to 0 with o_fault=0.
REQ-040 Reset pulsed during MEM_WR -> o_mem_write=0 and o_state=0 on the next cycle.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Bundle of the instruction, memory-handshake and datapath-control signals
// exchanged between the multicycle controller and its datapath.
//   master : datapath side (drives instr, mem_ready, branch_taken)
//   slave  : controller side (drives every o_* strobe, select, state, fault)
interface multicycle_control_if;
  logic [31:0] i_instr;         // instruction register contents
  logic        i_mem_ready;     // memory access completes this cycle
  logic        i_branch_taken;  // branch compare result (BRANCH state)
  logic        o_pc_write;      // PC load strobe
  logic        o_ir_write;      // IR load strobe
  logic        o_mem_read;      // memory read request
  logic        o_mem_write;     // memory write request
  logic        o_addr_sel;      // 0 = PC, 1 = ALU result register
  logic        o_reg_write;     // register file write strobe
  logic        o_alu_a_sel;     // 0 = PC, 1 = rs1
  logic [1:0]  o_alu_b_sel;     // 0 = rs2, 1 = immediate, 2 = constant 4
  logic [1:0]  o_alu_op;        // 0 = add, 1 = branch compare, 2 = funct
  logic [1:0]  o_wb_sel;        // 0 = ALU, 1 = memory, 2 = PC+4, 3 = imm
  logic [3:0]  o_state;         // current state encoding
  logic        o_fault;         // sticky fault flag

  modport master (
    output i_instr, i_mem_ready, i_branch_taken,
    input  o_pc_write, o_ir_write, o_mem_read, o_mem_write, o_addr_sel,
           o_reg_write, o_alu_a_sel, o_alu_b_sel, o_alu_op, o_wb_sel,
           o_state, o_fault
  );

  modport slave (
    input  i_instr, i_mem_ready, i_branch_taken,
    output o_pc_write, o_ir_write, o_mem_read, o_mem_write, o_addr_sel,
           o_reg_write, o_alu_a_sel, o_alu_b_sel, o_alu_op, o_wb_sel,
           o_state, o_fault
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control FSM.  Sequences fetch, decode, execute,
// memory and writeback phases and drives the datapath strobes/selects.
// Memory phases (FETCH, MEM_RD, MEM_WR) wait on i_mem_ready with a bounded
// wait counter; an expired wait or an unknown opcode raises a sticky fault
// and parks the block in HALT until reset.
// Ports:
//   i_clk   : clock, all state changes on its rising edge
//   i_reset : synchronous active-high reset
//   bus     : multicycle_control_if.slave (instr/handshake in, controls out)
// Parameter:
//   TIMEOUT : number of low-ready cycles tolerated in a memory phase (>= 1)
module multicycle_control #(
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  multicycle_control_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The wait that would make the counter reach TIMEOUT is the last one allowed.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_UJ   = 7'b1101111;
  localparam logic [6:0] OP_U    = 7'b0110111;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC     = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_WB       = 4'd6,
    ST_BRANCH   = 4'd7,
    ST_JUMP     = 4'd8,
    ST_HALT     = 4'd9
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic               fault_r, fault_nxt_s;

  logic               mem_phase_s;     // current state waits on i_mem_ready
  state_t             mem_done_st_s;   // where a completed access goes
  logic [6:0]         opcode_s;

  logic               pc_write_s, ir_write_s, mem_read_s, mem_write_s;
  logic               addr_sel_s, reg_write_s, alu_a_sel_s;
  logic [1:0]         alu_b_sel_s, alu_op_s, wb_sel_s;

  // Upper instruction bits belong to the datapath, not to control.
  logic               unused_instr_s;
  assign unused_instr_s = ^bus.i_instr[31:7];

  assign opcode_s = bus.i_instr[6:0];

  // State, wait counter and sticky fault registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= ST_FETCH;
      wait_cnt_r <= {CNT_W{1'b0}};
      fault_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      fault_r    <= fault_nxt_s;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = {CNT_W{1'b0}};  // cleared outside memory waits
    fault_nxt_s    = fault_r;
    mem_phase_s    = 1'b0;
    mem_done_st_s  = ST_FETCH;
    pc_write_s     = 1'b0;
    ir_write_s     = 1'b0;
    mem_read_s     = 1'b0;
    mem_write_s    = 1'b0;
    addr_sel_s     = 1'b0;
    reg_write_s    = 1'b0;
    alu_a_sel_s    = 1'b0;
    alu_b_sel_s    = 2'd0;
    alu_op_s       = 2'd0;
    wb_sel_s       = 2'd0;

    case (state_r)
      ST_FETCH: begin
        // Request at PC while the ALU forms PC+4 for the PC update.
        mem_read_s    = 1'b1;
        addr_sel_s    = 1'b0;
        alu_a_sel_s   = 1'b0;
        alu_b_sel_s   = 2'd2;
        alu_op_s      = 2'd0;
        mem_phase_s   = 1'b1;
        mem_done_st_s = ST_DECODE;
        if (bus.i_mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
        end else begin
          ir_write_s = 1'b0;
          pc_write_s = 1'b0;
        end
      end
      ST_DECODE: begin
        case (opcode_s)
          OP_R, OP_ADDI: state_nxt_s = ST_EXEC;
          OP_LD, OP_S:   state_nxt_s = ST_MEM_ADDR;
          OP_SB:         state_nxt_s = ST_BRANCH;
          OP_JALR, OP_UJ: state_nxt_s = ST_JUMP;
          OP_U:          state_nxt_s = ST_WB;
          default: begin
            state_nxt_s = ST_HALT;
            fault_nxt_s = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        alu_op_s = 2'd2;
        if (opcode_s == OP_ADDI) begin
          alu_b_sel_s = 2'd1;
        end else begin
          alu_b_sel_s = 2'd0;
        end
        state_nxt_s = ST_WB;
      end
      ST_MEM_ADDR: begin
        alu_a_sel_s = 1'b1;
        alu_b_sel_s = 2'd1;
        alu_op_s    = 2'd0;
        if (opcode_s == OP_LD) begin
          state_nxt_s = ST_MEM_RD;
        end else begin
          state_nxt_s = ST_MEM_WR;
        end
      end
      ST_MEM_RD: begin
        mem_read_s    = 1'b1;
        addr_sel_s    = 1'b1;
        mem_phase_s   = 1'b1;
        mem_done_st_s = ST_WB;
      end
      ST_MEM_WR: begin
        mem_write_s   = 1'b1;
        addr_sel_s    = 1'b1;
        mem_phase_s   = 1'b1;
        mem_done_st_s = ST_FETCH;
      end
      ST_WB: begin
        reg_write_s = 1'b1;
        // Writeback source follows from the instruction class.
        case (opcode_s)
          OP_LD:          wb_sel_s = 2'd1;
          OP_JALR, OP_UJ: wb_sel_s = 2'd2;
          OP_U:           wb_sel_s = 2'd3;
          default:        wb_sel_s = 2'd0;
        endcase
        state_nxt_s = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_op_s    = 2'd1;
        pc_write_s  = bus.i_branch_taken;
        state_nxt_s = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write_s  = 1'b1;
        alu_b_sel_s = 2'd1;
        alu_op_s    = 2'd0;
        if (opcode_s == OP_JALR) begin
          alu_a_sel_s = 1'b1;
        end else begin
          alu_a_sel_s = 1'b0;
        end
        state_nxt_s = ST_WB;
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        // Corrupted state encoding is treated as a fault.
        state_nxt_s = ST_HALT;
        fault_nxt_s = 1'b1;
      end
    endcase

    // Shared memory-wait handling: advance on ready, otherwise count until
    // the wait budget is exhausted and then abandon the access.
    if (mem_phase_s) begin
      if (bus.i_mem_ready) begin
        state_nxt_s = mem_done_st_s;
      end else if (wait_cnt_r == LAST_WAIT) begin
        state_nxt_s = ST_HALT;
        fault_nxt_s = 1'b1;
      end else begin
        wait_cnt_nxt_s = wait_cnt_r + CNT_W'(1'b1);
      end
    end else begin
      wait_cnt_nxt_s = {CNT_W{1'b0}};
    end
  end

  assign bus.o_pc_write  = pc_write_s;
  assign bus.o_ir_write  = ir_write_s;
  assign bus.o_mem_read  = mem_read_s;
  assign bus.o_mem_write = mem_write_s;
  assign bus.o_addr_sel  = addr_sel_s;
  assign bus.o_reg_write = reg_write_s;
  assign bus.o_alu_a_sel = alu_a_sel_s;
  assign bus.o_alu_b_sel = alu_b_sel_s;
  assign bus.o_alu_op    = alu_op_s;
  assign bus.o_wb_sel    = wb_sel_s;
  assign bus.o_state     = state_r;
  assign bus.o_fault     = fault_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.  A reference model keeps, per
// instruction, the list of states it must visit (a queue built from the
// opcode class); memory states stay at the head of the list while ready is
// low, subject to the wait budget.  Directed scenarios are followed by a
// randomized run with random instructions, ready, branch result and resets.
module tb_multicycle_control;
  localparam int TMO = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_UJ   = 7'b1101111;
  localparam logic [6:0] OP_U    = 7'b0110111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if bus();

  multicycle_control #(.TIMEOUT(TMO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          plan_q[$];      // states still to visit for this instruction
  logic [31:0] pending_q[$];   // directed instructions to issue next
  logic [31:0] cur_instr;
  int          waits;
  logic        exp_fault;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  function automatic logic [6:0] pick_opcode(input int idx);
    case (idx % 8)
      0: return OP_R;
      1: return OP_ADDI;
      2: return OP_LD;
      3: return OP_S;
      4: return OP_SB;
      5: return OP_JALR;
      6: return OP_UJ;
      default: return OP_U;
    endcase
  endfunction

  task automatic start_instr();
    int idx;
    logic [31:0] r;
    logic [6:0] op;
    if (pending_q.size() > 0) begin
      cur_instr = pending_q.pop_front();
    end else begin
      idx = $urandom_range(0, 16);
      op  = (idx == 16) ? 7'h7F : pick_opcode(idx);
      r   = $urandom();
      cur_instr = {r[31:7], op};
    end
    case (cur_instr[6:0])
      OP_R, OP_ADDI:  plan_q = {0, 1, 2, 6};
      OP_LD:          plan_q = {0, 1, 3, 4, 6};
      OP_S:           plan_q = {0, 1, 3, 5};
      OP_SB:          plan_q = {0, 1, 7};
      OP_JALR, OP_UJ: plan_q = {0, 1, 8, 6};
      OP_U:           plan_q = {0, 1, 6};
      default:        plan_q = {0, 1, 9};
    endcase
  endtask

  task automatic model_reset();
    waits     = 0;
    exp_fault = 1'b0;
    start_instr();
  endtask

  task automatic model_advance(input logic rdy);
    int s;
    s = plan_q[0];
    if (s == 9) begin
      // absorbing
    end else if ((s == 0 || s == 4 || s == 5) && !rdy) begin
      waits++;
      if (waits == TMO) begin
        plan_q    = {9};
        exp_fault = 1'b1;
      end
    end else begin
      void'(plan_q.pop_front());
      waits = 0;
      if (plan_q.size() == 0) start_instr();
      else if (plan_q[0] == 9) exp_fault = 1'b1;
    end
  endtask

  // stb = {pc_write, ir_write, mem_read, mem_write, reg_write}
  // sel = {addr_sel, alu_a_sel, alu_b_sel[1:0], alu_op[1:0], wb_sel[1:0]}
  function automatic void expect_out(input int s, input logic [6:0] op, input logic rdy,
                                     input logic tk, output logic [4:0] stb,
                                     output logic [7:0] sel, output logic [7:0] msk);
    stb = 5'b0; sel = 8'h00; msk = 8'h00;
    case (s)
      0: begin stb = {rdy, rdy, 1'b1, 1'b0, 1'b0}; sel = 8'b0_0_10_00_00; msk = 8'b1_1_11_11_00; end
      2: begin sel = {4'b0000, 2'd2, 2'd0}; sel[5:4] = (op == OP_ADDI) ? 2'd1 : 2'd0; msk = 8'b0_0_11_11_00; end
      3: begin sel = 8'b0_1_01_00_00; msk = 8'b0_1_11_11_00; end
      4: begin stb = 5'b00100; sel = 8'h80; msk = 8'h80; end
      5: begin stb = 5'b00010; sel = 8'h80; msk = 8'h80; end
      6: begin
        stb = 5'b00001; msk = 8'h03;
        if (op == OP_LD) sel[1:0] = 2'd1;
        else if (op == OP_JALR || op == OP_UJ) sel[1:0] = 2'd2;
        else if (op == OP_U) sel[1:0] = 2'd3;
        else sel[1:0] = 2'd0;
      end
      7: begin stb = {tk, 4'b0000}; sel = 8'b0_0_00_01_00; msk = 8'h0C; end
      8: begin stb = 5'b10000; sel[6] = (op == OP_JALR); msk = 8'h40; end
      default: begin end
    endcase
  endfunction

  task automatic cycle(input logic rdy, input logic tk);
    int s;
    logic [4:0] es, os;
    logic [7:0] esel, emsk, osel;
    s = plan_q[0];
    bus.i_mem_ready    = rdy;
    bus.i_branch_taken = tk;
    // Instruction is only meaningful where the controller may look at it.
    bus.i_instr = (s == 1 || s == 2 || s == 3 || s == 6 || s == 8) ? cur_instr : $urandom();
    @(negedge clk);
    expect_out(s, cur_instr[6:0], rdy, tk, es, esel, emsk);
    os   = {bus.o_pc_write, bus.o_ir_write, bus.o_mem_read, bus.o_mem_write, bus.o_reg_write};
    osel = {bus.o_addr_sel, bus.o_alu_a_sel, bus.o_alu_b_sel, bus.o_alu_op, bus.o_wb_sel};
    check_eq("state", 32'(bus.o_state), 32'(s));
    check_eq("fault", 32'(bus.o_fault), 32'(exp_fault));
    check_eq("strobes", 32'(os), 32'(es));
    if (emsk != 8'h00) check_eq("selects", 32'(osel & emsk), 32'(esel & emsk));
    @(posedge clk);
    model_advance(rdy);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_mem_ready    = 1'b0;
    bus.i_branch_taken = 1'b0;
    bus.i_instr        = $urandom();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.i_instr        = 32'h0;
    bus.i_mem_ready    = 1'b0;
    bus.i_branch_taken = 1'b0;

    // Reset state: only mem_read asserted, state FETCH, no fault.
    do_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    // ADDI with zero-wait memory: 0,1,2,6 then back to FETCH.
    pending_q.push_back(32'h00500093);
    do_reset();
    repeat (5) cycle(1'b1, 1'b0);

    // Load with three wait cycles in MEM_RD.
    pending_q.push_back(32'h00002083);
    do_reset();
    repeat (3) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);

    // Branch not taken, then taken.
    pending_q.push_back(32'h00208063);
    pending_q.push_back(32'h00208063);
    do_reset();
    repeat (3) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b1);

    // Jumps and LUI back to back.
    pending_q.push_back(32'h000080E7);
    pending_q.push_back(32'h008000EF);
    pending_q.push_back(32'h123450B7);
    do_reset();
    repeat (12) cycle(1'b1, 1'b0);

    // Illegal opcode: fault and HALT held for 20 cycles.
    pending_q.push_back(32'h0000007F);
    do_reset();
    repeat (2) cycle(1'b1, 1'b0);
    repeat (20) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Fetch timeout, then reset recovers.
    do_reset();
    repeat (7) cycle(1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 1'b0);

    // Reset in the middle of a store access.
    pending_q.push_back(32'h00112023);
    do_reset();
    repeat (3) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 1'b0);

    // Randomized run.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (plan_q[0] == 9 && $urandom_range(0, 3) == 0) do_reset();
      else if ($urandom_range(0, 199) == 0) do_reset();
      else cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
